// File: rtl/cursor_input_unit.sv
// Cursor and flip front end for the Minesweeper board: synchronised, debounced,
// auto-repeating buttons drive a clamped cursor. Define CURSOR_WRAP_EN to wrap at edges.
module cursor_input_unit #(
    parameter int GRID_COLS       = 16,
    parameter int GRID_ROWS       = 16,
    parameter int CELL_PX         = 24,
    parameter int X_ORIGIN        = 128,
    parameter int Y_ORIGIN        = 48,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         right,
    input  logic                         left,
    input  logic                         up,
    input  logic                         down,
    input  logic                         flip,
    input  logic                         enable,
    output logic [$clog2(GRID_COLS)-1:0] col,
    output logic [$clog2(GRID_ROWS)-1:0] row,
    output logic [9:0]                   x_topleft,
    output logic [8:0]                   y_topleft,
    output logic                         flip_pulse,
    output logic                         moved
);
    localparam int CW = $clog2(GRID_COLS);
    localparam int RWD = $clog2(GRID_ROWS);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RPT_MAX + 1);

    localparam logic [CW-1:0]  COL_MAX = CW'(GRID_COLS - 1);
    localparam logic [RWD-1:0] ROW_MAX = RWD'(GRID_ROWS - 1);
    localparam logic [9:0]     X_FIRST = 10'(X_ORIGIN);
    localparam logic [8:0]     Y_FIRST = 9'(Y_ORIGIN);
    localparam logic [9:0]     X_STEP  = 10'(CELL_PX);
    localparam logic [8:0]     Y_STEP  = 9'(CELL_PX);
`ifdef CURSOR_WRAP_EN
    localparam logic [9:0]     X_LAST  = 10'(X_ORIGIN + (GRID_COLS - 1) * CELL_PX);
    localparam logic [8:0]     Y_LAST  = 9'(Y_ORIGIN + (GRID_ROWS - 1) * CELL_PX);
`endif

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bit order: 0 right, 1 left, 2 up, 3 down, 4 flip
    logic [4:0] raw_s;
    logic [4:0] deb_s;
    logic [3:0] step_s;
    assign raw_s = {flip, down, up, left, right};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        logic          sync1_q;
        logic          sync2_q;
        logic          deb_q;
        logic [DW-1:0] cnt_q;

        // Synchroniser plus stability counter; state toggles once the counter reaches its limit
        always_ff @(posedge clock) begin
            if (reset) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                deb_q   <= 1'b0;
                cnt_q   <= {DW{1'b0}};
            end else begin
                sync1_q <= raw_s[g];
                sync2_q <= sync1_q;
                if (sync2_q == deb_q) begin
                    cnt_q <= {DW{1'b0}};
                end else if (cnt_q == DW'(DEBOUNCE_CYCLES)) begin
                    deb_q <= ~deb_q;
                    cnt_q <= {DW{1'b0}};
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end
        end
        assign deb_s[g] = deb_q;
    end

    for (genvar g = 0; g < 4; g++) begin : g_rpt
        rpt_state_e    state_q, state_d;
        logic [RW-1:0] cnt_q, cnt_d;
        logic          rpt_step;

        // Repeat FSM state register
        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= RPT_IDLE;
                cnt_q   <= {RW{1'b0}};
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // A release always wins over a due repeat, so no step fires on the falling edge
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            rpt_step = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    cnt_d = {RW{1'b0}};
                    if (deb_s[g]) begin
                        state_d  = RPT_DELAY;
                        rpt_step = 1'b1;
                    end else begin
                        state_d  = RPT_IDLE;
                    end
                end
                RPT_DELAY: begin
                    if (!deb_s[g]) begin
                        state_d = RPT_IDLE;
                        cnt_d   = {RW{1'b0}};
                    end else if (cnt_q == RW'(REPEAT_DELAY - 1)) begin
                        state_d  = RPT_REPEAT;
                        cnt_d    = {RW{1'b0}};
                        rpt_step = 1'b1;
                    end else begin
                        cnt_d = cnt_q + RW'(1);
                    end
                end
                RPT_REPEAT: begin
                    if (!deb_s[g]) begin
                        state_d = RPT_IDLE;
                        cnt_d   = {RW{1'b0}};
                    end else if (cnt_q == RW'(REPEAT_RATE - 1)) begin
                        cnt_d    = {RW{1'b0}};
                        rpt_step = 1'b1;
                    end else begin
                        cnt_d = cnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = RPT_IDLE;
                    cnt_d   = {RW{1'b0}};
                end
            endcase
        end
        assign step_s[g] = rpt_step;
    end

    logic h_inc_s, h_dec_s, v_inc_s, v_dec_s;
    assign h_inc_s = enable & step_s[0] & ~step_s[1];
    assign h_dec_s = enable & step_s[1] & ~step_s[0];
    assign v_inc_s = enable & step_s[3] & ~step_s[2];
    assign v_dec_s = enable & step_s[2] & ~step_s[3];

    logic [CW-1:0]  col_q, col_d;
    logic [RWD-1:0] row_q, row_d;
    logic [9:0]     x_q, x_d;
    logic [8:0]     y_q, y_d;
    logic           moved_q, flip_pulse_q, flip_prev_q;

    // Next column and pixel x, updated incrementally alongside the index
    always_comb begin
        col_d = col_q;
        x_d   = x_q;
        if (h_inc_s) begin
            if (col_q == COL_MAX) begin
`ifdef CURSOR_WRAP_EN
                col_d = {CW{1'b0}};
                x_d   = X_FIRST;
`else
                col_d = col_q;
                x_d   = x_q;
`endif
            end else begin
                col_d = col_q + CW'(1);
                x_d   = x_q + X_STEP;
            end
        end else if (h_dec_s) begin
            if (col_q == {CW{1'b0}}) begin
`ifdef CURSOR_WRAP_EN
                col_d = COL_MAX;
                x_d   = X_LAST;
`else
                col_d = col_q;
                x_d   = x_q;
`endif
            end else begin
                col_d = col_q - CW'(1);
                x_d   = x_q - X_STEP;
            end
        end else begin
            col_d = col_q;
            x_d   = x_q;
        end
    end

    // Next row and pixel y
    always_comb begin
        row_d = row_q;
        y_d   = y_q;
        if (v_inc_s) begin
            if (row_q == ROW_MAX) begin
`ifdef CURSOR_WRAP_EN
                row_d = {RWD{1'b0}};
                y_d   = Y_FIRST;
`else
                row_d = row_q;
                y_d   = y_q;
`endif
            end else begin
                row_d = row_q + RWD'(1);
                y_d   = y_q + Y_STEP;
            end
        end else if (v_dec_s) begin
            if (row_q == {RWD{1'b0}}) begin
`ifdef CURSOR_WRAP_EN
                row_d = ROW_MAX;
                y_d   = Y_LAST;
`else
                row_d = row_q;
                y_d   = y_q;
`endif
            end else begin
                row_d = row_q - RWD'(1);
                y_d   = y_q - Y_STEP;
            end
        end else begin
            row_d = row_q;
            y_d   = y_q;
        end
    end

    // Registered cursor position, move pulse and flip edge detector
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RWD{1'b0}};
            x_q          <= X_FIRST;
            y_q          <= Y_FIRST;
            moved_q      <= 1'b0;
            flip_prev_q  <= 1'b0;
            flip_pulse_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            x_q          <= x_d;
            y_q          <= y_d;
            moved_q      <= (col_d != col_q) | (row_d != row_q);
            flip_prev_q  <= deb_s[4];
            flip_pulse_q <= enable & deb_s[4] & ~flip_prev_q;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign x_topleft  = x_q;
    assign y_topleft  = y_q;
    assign moved      = moved_q;
    assign flip_pulse = flip_pulse_q;
endmodule

// File: tb/tb_cursor_input_unit.sv
// Scoreboard bench for cursor_input_unit: directed presses push expected events,
// a negedge monitor pops and compares whenever moved or flip_pulse is seen.
module tb_cursor_input_unit;
    logic       clock = 1'b0;
    logic       reset;
    logic       right, left, up, down, flip, enable;
    logic [2:0] col, row;
    logic [9:0] x_topleft;
    logic [8:0] y_topleft;
    logic       flip_pulse, moved;

    cursor_input_unit #(
        .GRID_COLS(8), .GRID_ROWS(8), .CELL_PX(32), .X_ORIGIN(192), .Y_ORIGIN(112),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_RATE(8)
    ) dut (
        .clock(clock), .reset(reset), .right(right), .left(left), .up(up), .down(down),
        .flip(flip), .enable(enable), .col(col), .row(row), .x_topleft(x_topleft),
        .y_topleft(y_topleft), .flip_pulse(flip_pulse), .moved(moved)
    );

    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int edge_at;
        bit is_flip;
        int c;
        int r;
        int x;
        int y;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  tests = 0;
    int  failed = 0;
    int  k, k2;

    task automatic expect_ev(input int e, input bit is_flip, input int c, input int r);
        exp_q.push_back('{e, is_flip, c, r, 192 + c * 32, 112 + r * 32});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && (moved || flip_pulse)) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_event: edge=%0d moved=%0b flip=%0b col=%0d row=%0d, expected no event",
                         edge_n, moved, flip_pulse, col, row);
            end else begin
                ev = exp_q.pop_front();
                if (edge_n != ev.edge_at || flip_pulse != ev.is_flip || moved != !ev.is_flip ||
                    col != 3'(ev.c) || row != 3'(ev.r) ||
                    x_topleft != 10'(ev.x) || y_topleft != 9'(ev.y)) begin
                    failed++;
                    $display("FAIL event: got edge=%0d flip=%0b moved=%0b col=%0d row=%0d x=%0d y=%0d, expected edge=%0d flip=%0b col=%0d row=%0d x=%0d y=%0d",
                             edge_n, flip_pulse, moved, col, row, x_topleft, y_topleft,
                             ev.edge_at, ev.is_flip, ev.c, ev.r, ev.x, ev.y);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; right = 1'b0; left = 1'b0; up = 1'b0; down = 1'b0;
        flip = 1'b0; enable = 1'b1;
        idle(3);
        check("reset_col", int'(col), 0);
        check("reset_row", int'(row), 0);
        check("reset_x", int'(x_topleft), 192);
        check("reset_y", int'(y_topleft), 112);
        check("reset_moved", int'(moved), 0);
        check("reset_flip", int'(flip_pulse), 0);
        reset = 1'b0;
        idle(5);

        // Single right press: one step, 7 edges after first sample
        k = edge_n; right = 1'b1; expect_ev(k + 8, 1'b0, 1, 0);
        idle(10); right = 1'b0; idle(20);

        // Bouncing flip: one pulse 7 edges after the stable-high start
        k = edge_n; flip = 1'b1; idle(2); flip = 1'b0; idle(1); flip = 1'b1;
        expect_ev(k + 11, 1'b1, 1, 0);
        idle(20); flip = 1'b0; idle(15);

        // Held down: initial step, then delay and rate repeats
        k = edge_n; down = 1'b1;
        expect_ev(k + 8, 1'b0, 1, 1);
        expect_ev(k + 24, 1'b0, 1, 2);
        expect_ev(k + 32, 1'b0, 1, 3);
        expect_ev(k + 40, 1'b0, 1, 4);
        idle(40); down = 1'b0; idle(20);
        check("hold_row", int'(row), 4);
        check("hold_y", int'(y_topleft), 240);

        // Left to col 0, then left past the edge
        k = edge_n; left = 1'b1; expect_ev(k + 8, 1'b0, 0, 4);
        idle(10); left = 1'b0; idle(20);
        k = edge_n; left = 1'b1;
`ifdef CURSOR_WRAP_EN
        expect_ev(k + 8, 1'b0, 7, 4);
`endif
        idle(10); left = 1'b0; idle(20);
`ifdef CURSOR_WRAP_EN
        check("edge_col", int'(col), 7);
        check("edge_x", int'(x_topleft), 416);
        k = edge_n; right = 1'b1; expect_ev(k + 8, 1'b0, 0, 4);
        idle(10); right = 1'b0; idle(20);
`else
        check("edge_col", int'(col), 0);
        check("edge_x", int'(x_topleft), 192);
`endif

        // Opposite directions cancel; orthogonal ones both apply
        right = 1'b1; left = 1'b1; idle(10); right = 1'b0; left = 1'b0; idle(20);
        check("cancel_col", int'(col), 0);
        k = edge_n; right = 1'b1; down = 1'b1; expect_ev(k + 8, 1'b0, 1, 5);
        idle(10); right = 1'b0; down = 1'b0; idle(20);

        // Disabled flip is discarded
        enable = 1'b0; flip = 1'b1; idle(12); flip = 1'b0; idle(15); enable = 1'b1; idle(5);

        // Disabled initial step is dropped; re-enable resumes at the repeat phase
        enable = 1'b0; k = edge_n; right = 1'b1;
        idle(12); enable = 1'b1; expect_ev(k + 24, 1'b0, 2, 5);
        idle(12); right = 1'b0; idle(20);
        check("resume_col", int'(col), 2);

        // Reset during a repeat hold, then the still-held button re-debounces
        k = edge_n; right = 1'b1;
        expect_ev(k + 8, 1'b0, 3, 5);
        expect_ev(k + 24, 1'b0, 4, 5);
        expect_ev(k + 32, 1'b0, 5, 5);
        idle(35); reset = 1'b1; idle(1);
        check("midreset_col", int'(col), 0);
        check("midreset_row", int'(row), 0);
        check("midreset_x", int'(x_topleft), 192);
        check("midreset_y", int'(y_topleft), 112);
        idle(1); reset = 1'b0; k2 = edge_n;
        expect_ev(k2 + 8, 1'b0, 1, 0);
        idle(8); right = 1'b0; idle(25);

        check("final_col", int'(col), 1);
        check("final_row", int'(row), 0);
        check("pending_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/cursor_input_unit.md
# cursor_input_unit

Parametrised cursor and input front end for the Minesweeper top level. It replaces the externally driven `x_topleft`/`y_topleft` test inputs with positions generated internally from the raw `right`/`left`/`up`/`down`/`flip` buttons. Each button is synchronised and debounced. Direction buttons auto-repeat while held. The unit tracks the selected cell on a GRID_COLS × GRID_ROWS board and publishes the cell index, its pixel top-left corner, and single-cycle flip pulses to the processor's `pressed` and `x_game`/`y_game` inputs.

## Interface
- GRID_COLS, 16: board columns; must be ≥ 2.
- GRID_ROWS, 16: board rows; must be ≥ 2.
- CELL_PX, 24: cell edge in pixels.
- X_ORIGIN, 128: pixel x of cell (0,0). Requires X_ORIGIN + GRID_COLS·CELL_PX ≤ 640.
- Y_ORIGIN, 48: pixel y of cell (0,0). Requires Y_ORIGIN + GRID_ROWS·CELL_PX ≤ 480.
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised samples required to change a debounced state; must be ≥ 1.
- REPEAT_DELAY, 25000000: hold cycles before the first auto-repeat.
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeats.
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- right, left, up, down, flip  in  1 each  raw asynchronous buttons, active-high.
- enable  in  1  when low, moves and flips are suppressed; debouncers keep running.
- col  out  clog2(GRID_COLS)  selected column.
- row  out  clog2(GRID_ROWS)  selected row.
- x_topleft  out  10  X_ORIGIN + col·CELL_PX.
- y_topleft  out  9  Y_ORIGIN + row·CELL_PX.
- flip_pulse  out  1  one-cycle pulse per debounced flip press.
- moved  out  1  one-cycle pulse when col or row changed this cycle.

## Operation
- Each button path: 2-flop synchroniser, then a debounce counter. The counter resets whenever the synchronised value equals the debounced state. When it reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
- Per-direction repeat FSM with states IDLE, DELAY, REPEAT:
  - IDLE → DELAY on debounced rising edge; emit one step.
  - DELAY → REPEAT when the hold count reaches REPEAT_DELAY; emit one step.
  - In REPEAT, emit one step every REPEAT_RATE cycles.
  - Any state → IDLE on debounced fall.
- Horizontal net = right_step − left_step. Vertical net = down_step − up_step. Opposite steps in the same cycle cancel. Horizontal and vertical steps in the same cycle both apply.
- Edge behaviour: steps past col 0 / GRID_COLS−1 or row 0 / GRID_ROWS−1 are clamped, or wrap when configured (see Configuration).
- A step that does not change the position (clamped) produces no `moved` pulse.
- flip: debounced rising edge gives a one-cycle `flip_pulse`. No auto-repeat; holding the button produces exactly one pulse.
- `enable` low: steps and flip edges are discarded, not queued. Repeat FSMs still advance, so re-enabling mid-hold resumes at the current repeat phase.
- Pixel arithmetic is computed from the next-state col/row and registered, so `x_topleft`/`y_topleft` always match `col`/`row` in the same cycle. No multiplier inference required; an incremental ±CELL_PX update is acceptable.

## Timing
- Reset values:
  - col = 0, row = 0.
  - x_topleft = X_ORIGIN, y_topleft = Y_ORIGIN.
  - flip_pulse = 0, moved = 0.
  - All synchronisers, debounced states and counters = 0; repeat FSMs in IDLE.
- Latency, for a raw rising edge first sampled at edge t and held stable:
  - debounced state high at edge t+2+DEBOUNCE_CYCLES;
  - col/row/x/y, `moved` and `flip_pulse` updated at edge t+3+DEBOUNCE_CYCLES.
- Glitch shorter than DEBOUNCE_CYCLES after synchronisation: no output change.
- First auto-repeat comes REPEAT_DELAY cycles after the initial step; later repeats follow every REPEAT_RATE cycles.
- Reset asserted mid-hold: everything returns to reset values on the next edge. A button still held after reset release counts as a new press once re-debounced.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- CURSOR_WRAP_EN defined: a step past an edge wraps. col GRID_COLS−1 + right → 0; col 0 + left → GRID_COLS−1; rows likewise. A wrap produces a `moved` pulse.
- CURSOR_WRAP_EN undefined: a step past an edge saturates at the edge with no `moved` pulse.

## Test plan
All scenarios use GRID_COLS=8, GRID_ROWS=8, CELL_PX=32, X_ORIGIN=192, Y_ORIGIN=112, DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8.
- Reset, then press right at edge 10 and hold 10 cycles → col=1, x_topleft=224, moved=1 at edge 17 only.
- Flip bounce: flip high 2 cycles, low 1 cycle, then high 20 cycles → exactly one flip_pulse, 7 cycles after the stable-high start.
- Hold down 40 cycles from row 0 → steps at +7, +23, +31, +39 relative to press start; row=4, y_topleft=240.
- Left at col 0 → without CURSOR_WRAP_EN: col stays 0, no moved. With it: col=7, x_topleft=416, moved=1.
- Right and left pressed in the same cycle → col unchanged, no moved. Right with down in the same cycle → col+1 and row+1 in one cycle.
- enable=0 during a flip press → no flip_pulse. Reset asserted during a REPEAT hold → col=0, row=0 next edge; re-debounced press steps again.
